// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error-statistics harness for a small approximate multiplier.
// Sweeps every operand pair and accumulates error statistics against the exact product.
module approx_mul_err_sweep #(
    parameter int W       = 4,
    parameter int MUL_LAT = 0,
    parameter int SUM_W   = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [W-1:0]        op_a,
    output logic [W-1:0]        op_b,
    input  logic [2*W-1:0]      approx_r,
    output logic                busy,
    output logic                done,
    output logic [2*W:0]        err_count,
    output logic [SUM_W-1:0]    err_sum,
    output logic signed [SUM_W:0] bias_sum,
    output logic [2*W-1:0]      max_err,
    output logic [W-1:0]        worst_a,
    output logic [W-1:0]        worst_b
);

    localparam int PW = 2 * W;
    localparam int DW = PW + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] idx, idx_nx;
    logic          op_valid, op_valid_nx;
    logic [2:0]    drain_cnt, drain_cnt_nx;
    logic          accept;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            op_valid  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            op_valid  <= op_valid_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        op_valid_nx  = op_valid;
        drain_cnt_nx = drain_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept      = 1'b1;
                    state_nx    = SWEEP;
                    idx_nx      = '0;
                    op_valid_nx = 1'b1;
                end
            end
            SWEEP: begin
                if (idx == '1) begin
                    state_nx     = DRAIN;
                    op_valid_nx  = 1'b0;
                    drain_cnt_nx = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            DRAIN: begin
                // Wait out the multiplier latency plus both internal stages.
                if (drain_cnt == 3'(MUL_LAT + 1)) state_nx = DONE;
                else                              drain_cnt_nx = drain_cnt + 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign op_a = idx[W-1:0];
    assign op_b = idx[PW-1:W];
    assign busy = (state == SWEEP) || (state == DRAIN);
    assign done = (state == DONE);

    // Operand alignment: carries {valid, op_b, op_a} alongside the multiplier latency.
    logic [DW-1:0] d_vec;

    if (MUL_LAT == 0) begin : g_no_delay
        assign d_vec = {op_valid, idx};
    end else begin : g_delay
        logic [DW-1:0] line [MUL_LAT];

        // NOTE: the delay line is small and carries the valid bit, so it is reset like any other register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < MUL_LAT; i++) line[i] <= '0;
            end else begin
                line[0] <= {op_valid, idx};
                for (int i = 1; i < MUL_LAT; i++) line[i] <= line[i-1];
            end
        end

        assign d_vec = line[MUL_LAT-1];
    end

    logic [W-1:0]         d_a, d_b;
    logic                 d_valid;
    logic [PW-1:0]        exact_c;
    logic signed [DW-1:0] diff_c;
    logic [PW-1:0]        abs_c;

    assign d_a     = d_vec[W-1:0];
    assign d_b     = d_vec[PW-1:W];
    assign d_valid = d_vec[PW];
    assign exact_c = PW'(d_a) * PW'(d_b);
    assign diff_c  = $signed({1'b0, approx_r}) - $signed({1'b0, exact_c});
    assign abs_c   = diff_c[PW] ? PW'(-diff_c) : PW'(diff_c);

    logic                 s1_valid;
    logic [W-1:0]         s1_a, s1_b;
    logic signed [DW-1:0] s1_diff;
    logic [PW-1:0]        s1_abs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_diff  <= '0;
            s1_abs   <= '0;
        end else begin
            s1_valid <= d_valid;
            s1_a     <= d_a;
            s1_b     <= d_b;
            s1_diff  <= diff_c;
            s1_abs   <= abs_c;
        end
    end

    // Accumulators; strict '>' keeps the earliest pair on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            err_sum   <= '0;
            bias_sum  <= '0;
            max_err   <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (accept) begin
            err_count <= '0;
            err_sum   <= '0;
            bias_sum  <= '0;
            max_err   <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (s1_valid) begin
            err_count <= err_count + DW'(s1_diff != '0);
            err_sum   <= err_sum + SUM_W'(s1_abs);
            bias_sum  <= bias_sum + (SUM_W + 1)'(s1_diff);
            if (s1_abs > max_err) begin
                max_err <= s1_abs;
                worst_a <= s1_a;
                worst_b <= s1_b;
            end
        end
    end

endmodule
